alu_multibyte_sequencer: RTL and testbench
==========================================

Name: alu_multibyte_sequencer

Overview:
Sequences one eight_bit_alu instance over NUM_BYTES cycles to run multi-byte (16/24/32-bit) operations, LSB byte first. Carry/borrow is chained between bytes through a register. Flags are computed over the full-width result. Sits between the operand/command source and the result consumer, with a valid/ready handshake on both sides.

Parameters:
NUM_BYTES, 2, operand width in bytes; legal range 2..4; W = 8*NUM_BYTES.

Ports:
clk_i  input  1  clock, all state rises on posedge
rst_n_i  input  1  asynchronous active-low reset
start_i  input  1  command valid
ready_o  output  1  command ready; high only in IDLE
a_i  input  W  operand A
b_i  input  W  operand B
f_i  input  `CONTROL_WIDTH  ALU function code
carry_borrow_i  input  1  carry/borrow into byte 0
out_valid_o  output  1  result valid; high only in DONE
out_ready_i  input  1  consumer accepts result
y_o  output  W  full-width result
carry_borrow_o  output  1  final carry (ADD) or borrow (SUB); 0 for other codes
status_flag_o  output  2  full-width status flag
busy_o  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (async, any state including mid-RUN): state=IDLE, byte_idx=0, carry_reg=0, result_reg=0, y_o=0, carry_borrow_o=0, status_flag_o=`DEFAULT_FLAG, out_valid_o=0, ready_o=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - On start_i=1, latch a_i, b_i, f_i and carry_borrow_i (into carry_reg); set byte_idx=0; go to RUN.
  - Outputs keep their previous values.
- RUN, one byte per cycle:
  - ALU inputs: a8=a_reg[8*idx+:8], b8=b_reg[8*idx+:8], f8=f_reg, carry_borrow_i=carry_reg.
  - result_reg[8*idx+:8] <= ALU y8_o.
  - carry_reg <= ALU carry_borrow_o. This is 0 for non-arith codes, so no chaining occurs.
  - idx increments. When idx==NUM_BYTES-1, go to DONE after the write.
- DONE:
  - y_o=result_reg; carry_borrow_o=carry_reg for `OUTPUT_A_PLUS_B/`OUTPUT_A_MINUS_B, else 0.
  - Flag for ADD: final carry=1 gives `OVERFLOW_FLAG; else W-bit result==0 gives `ZERO_FLAG; else `DEFAULT_FLAG.
  - Flag for SUB: final borrow=1 gives `NEGATIVE_FLAG; else result==0 gives `ZERO_FLAG; else `DEFAULT_FLAG.
  - Flag for other codes: result==0 gives `ZERO_FLAG; else `DEFAULT_FLAG.
  - Per-byte ALU flags are ignored.
  - y_o, carry_borrow_o and status_flag_o are registered, stable from DONE entry until the next accepted command completes.
- Latency: command accepted at edge N; out_valid_o=1 from edge N+NUM_BYTES.
- Output handshake:
  - out_valid_o stays high until out_ready_i=1 is sampled; then go to IDLE.
  - out_ready_i=1 on the first DONE cycle is accepted immediately.
  - No same-cycle start acceptance in DONE, so the back-to-back throughput is one command per NUM_BYTES+2 cycles.
- Protection:
  - start_i while busy is ignored and not queued.
  - Changes to a_i/b_i/f_i after acceptance have no effect.
  - out_ready_i outside DONE is ignored.
- Width rule: no sign extension; operands are unsigned W-bit; the result wraps mod 2^W.

Decomposition:
- Shared define header: `DATA_WIDTH, `CONTROL_WIDTH, the function codes (`OUTPUT_A_PLUS_B, `OUTPUT_A_MINUS_B, …) and the flag codes (`DEFAULT_FLAG, `ZERO_FLAG, `OVERFLOW_FLAG, `NEGATIVE_FLAG).
- Add the sequencer state encodings (SEQ_IDLE, SEQ_RUN, SEQ_DONE) to the same header.
- One sub-module: the existing eight_bit_alu, instantiated once. No new sub-module.

Test Plan:
All scenarios use NUM_BYTES=2.
1. ADD 0x00FF+0x0001, cin=0 -> y_o=0x0100, carry_borrow_o=0, `DEFAULT_FLAG; out_valid_o rises exactly 2 edges after accept; ready_o low for those 2 cycles.
2. ADD 0xFFFF+0x0001 -> y_o=0x0000, carry_borrow_o=1, `OVERFLOW_FLAG (overflow takes priority over zero). Also ADD 0x00FF+0x0000 with cin=1 -> y_o=0x0100, showing carry_borrow_i enters byte 0 only.
3. SUB 0x0100-0x0001 -> 0x00FF, borrow 0, `DEFAULT_FLAG. SUB 0x0001-0x0002 -> 0xFFFF, borrow 1, `NEGATIVE_FLAG. SUB 0x1234-0x1234 -> 0x0000, `ZERO_FLAG.
4. Non-arith code with byte-disjoint operands giving a zero result -> carry_borrow_o=0, `ZERO_FLAG; no carry propagates into byte 1.
5. Handshake:
   - start_i pulsed during RUN with different operands -> ignored; the original result is returned.
   - out_ready_i held low for 5 cycles in DONE -> out_valid_o and y_o stay stable.
   - out_ready_i then high -> IDLE next edge, ready_o=1.
6. rst_n_i asserted mid-RUN (after byte 0) -> outputs immediately 0/`DEFAULT_FLAG, out_valid_o=0, ready_o=1. A fresh ADD 0x0102+0x0304 then returns 0x0406.

Source files
------------

// File: rtl/alu_multibyte_sequencer_pkg.sv
// Shared ALU/sequencer codes and the sequencer's package of types and helpers.
`ifndef ALU_MULTIBYTE_SEQUENCER_DEFINES_SVH
`define ALU_MULTIBYTE_SEQUENCER_DEFINES_SVH
`define DATA_WIDTH        8
`define CONTROL_WIDTH     3
`define OUTPUT_A_PLUS_B   3'd0
`define OUTPUT_A_MINUS_B  3'd1
`define OUTPUT_A_AND_B    3'd2
`define OUTPUT_A_OR_B     3'd3
`define OUTPUT_A_XOR_B    3'd4
`define OUTPUT_NOT_A      3'd5
`define OUTPUT_A          3'd6
`define OUTPUT_B          3'd7
`define DEFAULT_FLAG      2'b00
`define ZERO_FLAG         2'b01
`define OVERFLOW_FLAG     2'b10
`define NEGATIVE_FLAG     2'b11
`define SEQ_IDLE          2'd0
`define SEQ_RUN           2'd1
`define SEQ_DONE          2'd2
`endif

package alu_multibyte_sequencer_pkg;

  localparam int unsigned BYTE_W = `DATA_WIDTH;
  localparam int unsigned CTRL_W = `CONTROL_WIDTH;
  localparam int unsigned FLAG_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = `SEQ_IDLE,
    ST_RUN  = `SEQ_RUN,
    ST_DONE = `SEQ_DONE
  } seq_state_e;

  // True for the codes whose carry/borrow is meaningful.
  function automatic logic is_arith(input logic [CTRL_W-1:0] f);
    return (f == `OUTPUT_A_PLUS_B) || (f == `OUTPUT_A_MINUS_B);
  endfunction

  // Full-width status flag; carry/borrow outranks zero for arithmetic codes.
  function automatic logic [FLAG_W-1:0] full_flag(input logic [CTRL_W-1:0] f,
                                                  input logic cb,
                                                  input logic is_zero);
    logic [FLAG_W-1:0] flag;
    flag = `DEFAULT_FLAG;
    if (is_zero) flag = `ZERO_FLAG;
    if ((f == `OUTPUT_A_PLUS_B) && cb) flag = `OVERFLOW_FLAG;
    if ((f == `OUTPUT_A_MINUS_B) && cb) flag = `NEGATIVE_FLAG;
    return flag;
  endfunction

endpackage

// File: rtl/alu_multibyte_sequencer_alu.sv
// Combinational eight-bit ALU slice with carry/borrow in and out.
module eight_bit_alu
  import alu_multibyte_sequencer_pkg::*;
(
  input  logic [BYTE_W-1:0] a8_i,
  input  logic [BYTE_W-1:0] b8_i,
  input  logic [CTRL_W-1:0] f8_i,
  input  logic              carry_borrow_i,
  output logic [BYTE_W-1:0] y8_o,
  output logic              carry_borrow_o
);

  logic [BYTE_W:0] sum;
  logic [BYTE_W:0] diff;

  // Byte result; bit BYTE_W of the 9-bit sum/difference is the carry/borrow.
  always_comb begin
    sum            = {1'b0, a8_i} + {1'b0, b8_i} + (BYTE_W+1)'(carry_borrow_i);
    diff           = {1'b0, a8_i} - {1'b0, b8_i} - (BYTE_W+1)'(carry_borrow_i);
    y8_o           = '0;
    carry_borrow_o = 1'b0;
    case (f8_i)
      `OUTPUT_A_PLUS_B:  {carry_borrow_o, y8_o} = sum;
      `OUTPUT_A_MINUS_B: {carry_borrow_o, y8_o} = diff;
      `OUTPUT_A_AND_B:   y8_o = a8_i & b8_i;
      `OUTPUT_A_OR_B:    y8_o = a8_i | b8_i;
      `OUTPUT_A_XOR_B:   y8_o = a8_i ^ b8_i;
      `OUTPUT_NOT_A:     y8_o = ~a8_i;
      `OUTPUT_A:         y8_o = a8_i;
      default:           y8_o = b8_i;
    endcase
  end

endmodule

// File: rtl/alu_multibyte_sequencer.sv
// Runs one eight-bit ALU over NUM_BYTES cycles, LSB first, with chained carry.
module alu_multibyte_sequencer
  import alu_multibyte_sequencer_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  output logic                      ready_o,
  input  logic [BYTE_W*NUM_BYTES-1:0] a_i,
  input  logic [BYTE_W*NUM_BYTES-1:0] b_i,
  input  logic [CTRL_W-1:0]         f_i,
  input  logic                      carry_borrow_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [BYTE_W*NUM_BYTES-1:0] y_o,
  output logic                      carry_borrow_o,
  output logic [FLAG_W-1:0]         status_flag_o,
  output logic                      busy_o
);

  localparam int unsigned W     = BYTE_W * NUM_BYTES;
  localparam int unsigned IDX_W = (NUM_BYTES > 2) ? 2 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [CTRL_W-1:0] f_q, f_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      result_q, result_d;
  logic [W-1:0]      y_q, y_d;
  logic              cb_out_q, cb_out_d;
  logic [FLAG_W-1:0] flag_q, flag_d;
  logic              out_valid_q, out_valid_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  int unsigned       lsb;
  logic [BYTE_W-1:0] alu_a, alu_b, alu_y;
  logic              alu_cb;
  logic [W-1:0]      res_next;

  // Byte lane feeding the ALU in the current RUN cycle.
  always_comb begin
    lsb   = BYTE_W * 32'(idx_q);
    alu_a = a_q[lsb +: BYTE_W];
    alu_b = b_q[lsb +: BYTE_W];
  end

  eight_bit_alu u_alu (
    .a8_i           (alu_a),
    .b8_i           (alu_b),
    .f8_i           (f_q),
    .carry_borrow_i (carry_q),
    .y8_o           (alu_y),
    .carry_borrow_o (alu_cb)
  );

  // Next-state and next-output logic; outputs load only on RUN->DONE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    f_d       = f_q;
    carry_d   = carry_q;
    result_d  = result_q;
    y_d       = y_q;
    cb_out_d  = cb_out_q;
    flag_d    = flag_q;
    res_next  = result_q;
    res_next[lsb +: BYTE_W] = alu_y;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          f_d     = f_i;
          carry_d = carry_borrow_i;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d = res_next;
        carry_d  = alu_cb;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          state_d  = ST_DONE;
          y_d      = res_next;
          cb_out_d = is_arith(f_q) ? alu_cb : 1'b0;
          flag_d   = full_flag(f_q, alu_cb, res_next == '0);
        end
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d     = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      y_q         <= '0;
      cb_out_q    <= 1'b0;
      flag_q      <= `DEFAULT_FLAG;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      f_q         <= f_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      y_q         <= y_d;
      cb_out_q    <= cb_out_d;
      flag_q      <= flag_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign ready_o        = ready_q;
  assign out_valid_o    = out_valid_q;
  assign y_o            = y_q;
  assign carry_borrow_o = cb_out_q;
  assign status_flag_o  = flag_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_alu_multibyte_sequencer.sv
// Directed bench for the two-byte sequencer configuration.
module tb_alu_multibyte_sequencer;

  localparam int unsigned NB = 2;
  localparam int unsigned W  = 8 * NB;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic          ready_o;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic [2:0]    f_i = '0;
  logic          carry_borrow_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [W-1:0]  y_o;
  logic          carry_borrow_o;
  logic [1:0]    status_flag_o;
  logic          busy_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  alu_multibyte_sequencer #(.NUM_BYTES(NB)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .start_i        (start_i),
    .ready_o        (ready_o),
    .a_i            (a_i),
    .b_i            (b_i),
    .f_i            (f_i),
    .carry_borrow_i (carry_borrow_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .y_o            (y_o),
    .carry_borrow_o (carry_borrow_o),
    .status_flag_o  (status_flag_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a command for one edge; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] f, input logic cin);
    @(posedge clk_i); #1;
    start_i = 1'b1; a_i = a; b_i = b; f_i = f; carry_borrow_i = cin;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] f, input logic cin, input logic [W-1:0] exp_y,
                        input logic exp_c, input logic [1:0] exp_flag);
    issue(a, b, f, cin);
    check_eq({name, "_ready_run0"}, 32'(ready_o), 32'd0);
    check_eq({name, "_valid_run0"}, 32'(out_valid_o), 32'd0);
    @(posedge clk_i); #1;
    check_eq({name, "_ready_run1"}, 32'(ready_o), 32'd0);
    check_eq({name, "_valid_run1"}, 32'(out_valid_o), 32'd0);
    @(posedge clk_i); #1;
    check_eq({name, "_valid"}, 32'(out_valid_o), 32'd1);
    check_eq({name, "_y"}, 32'(y_o), 32'(exp_y));
    check_eq({name, "_cb"}, 32'(carry_borrow_o), 32'(exp_c));
    check_eq({name, "_flag"}, 32'(status_flag_o), 32'(exp_flag));
    drain();
    check_eq({name, "_ready_idle"}, 32'(ready_o), 32'd1);
    check_eq({name, "_valid_idle"}, 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    // Reset values
    #12;
    check_eq("rst_ready", 32'(ready_o), 32'd1);
    check_eq("rst_valid", 32'(out_valid_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_y", 32'(y_o), 32'd0);
    check_eq("rst_flag", 32'(status_flag_o), 32'(`DEFAULT_FLAG));
    rst_n_i = 1'b1;

    // Arithmetic
    run_op("add_ff_1",   16'h00FF, 16'h0001, `OUTPUT_A_PLUS_B,  1'b0, 16'h0100, 1'b0, `DEFAULT_FLAG);
    run_op("add_wrap",   16'hFFFF, 16'h0001, `OUTPUT_A_PLUS_B,  1'b0, 16'h0000, 1'b1, `OVERFLOW_FLAG);
    run_op("add_cin",    16'h00FF, 16'h0000, `OUTPUT_A_PLUS_B,  1'b1, 16'h0100, 1'b0, `DEFAULT_FLAG);
    run_op("sub_borrow", 16'h0100, 16'h0001, `OUTPUT_A_MINUS_B, 1'b0, 16'h00FF, 1'b0, `DEFAULT_FLAG);
    run_op("sub_neg",    16'h0001, 16'h0002, `OUTPUT_A_MINUS_B, 1'b0, 16'hFFFF, 1'b1, `NEGATIVE_FLAG);
    run_op("sub_zero",   16'h1234, 16'h1234, `OUTPUT_A_MINUS_B, 1'b0, 16'h0000, 1'b0, `ZERO_FLAG);

    // Logic codes: no carry chaining even with cin set
    run_op("and_zero",   16'h00FF, 16'hFF00, `OUTPUT_A_AND_B,   1'b1, 16'h0000, 1'b0, `ZERO_FLAG);
    run_op("xor_ones",   16'h00FF, 16'hFF00, `OUTPUT_A_XOR_B,   1'b1, 16'hFFFF, 1'b0, `DEFAULT_FLAG);

    // Start during RUN is ignored; DONE holds while out_ready_i is low
    issue(16'h1000, 16'h0234, `OUTPUT_A_PLUS_B, 1'b0);
    start_i = 1'b1; a_i = 16'hFFFF; b_i = 16'hFFFF; f_i = `OUTPUT_A_MINUS_B; carry_borrow_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check_eq("hs_valid", 32'(out_valid_o), 32'd1);
    check_eq("hs_y", 32'(y_o), 32'h1234);
    check_eq("hs_flag", 32'(status_flag_o), 32'(`DEFAULT_FLAG));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check_eq($sformatf("hs_hold_valid%0d", i), 32'(out_valid_o), 32'd1);
      check_eq($sformatf("hs_hold_y%0d", i), 32'(y_o), 32'h1234);
    end
    drain();
    check_eq("hs_ready", 32'(ready_o), 32'd1);
    check_eq("hs_valid_low", 32'(out_valid_o), 32'd0);
    check_eq("hs_busy_low", 32'(busy_o), 32'd0);
    check_eq("hs_y_kept", 32'(y_o), 32'h1234);
    @(posedge clk_i); #1;
    check_eq("hs_not_queued", 32'(ready_o), 32'd1);

    // Async reset mid-RUN
    run_op("pre_rst", 16'h0001, 16'h0002, `OUTPUT_A_MINUS_B, 1'b0, 16'hFFFF, 1'b1, `NEGATIVE_FLAG);
    issue(16'h1111, 16'h2222, `OUTPUT_A_PLUS_B, 1'b0);
    @(posedge clk_i); #2;
    rst_n_i = 1'b0;
    #1;
    check_eq("mid_rst_y", 32'(y_o), 32'd0);
    check_eq("mid_rst_cb", 32'(carry_borrow_o), 32'd0);
    check_eq("mid_rst_flag", 32'(status_flag_o), 32'(`DEFAULT_FLAG));
    check_eq("mid_rst_valid", 32'(out_valid_o), 32'd0);
    check_eq("mid_rst_ready", 32'(ready_o), 32'd1);
    check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
    #3;
    rst_n_i = 1'b1;
    run_op("post_rst", 16'h0102, 16'h0304, `OUTPUT_A_PLUS_B, 1'b0, 16'h0406, 1'b0, `DEFAULT_FLAG);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
